// File: rtl/mips_reg_file_sb.sv
// Scoreboarded register file: 2 comb read ports, 1 sync write port, per-register pending-write counters.
// Latency: reads/hazards/iss_full combinational; writes and counters update at posedge clk; wb_err registered.
// Backpressure: issuing stage stalls on iss_full; decode stalls on hazard_a/b. RF_BYPASS_EN adds write-through forwarding.
module mips_reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int PEND_W   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              hazard_a,
    output logic              hazard_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              iss_full,
    output logic              wb_err
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [PEND_W-1:0] cnt_q  [DEPTH];
    logic [PEND_W-1:0] cnt_d  [DEPTH];
    logic              wb_err_q, wb_err_d;
    logic [DEPTH-1:0]  inc_vec, dec_vec;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // One-hot issue/writeback decodes; the hardwired zero register is never counted.
    always_comb begin
        inc_vec = iss_en ? (DEPTH'(1) << iss_addr) : '0;
        dec_vec = wr_en  ? (DEPTH'(1) << wr_addr)  : '0;
        if (ZERO_REG != 0) begin
            inc_vec[0] = 1'b0;
            dec_vec[0] = 1'b0;
        end
    end

    always_comb begin
        wb_err_d = wb_err_q;
        for (int r = 0; r < DEPTH; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc_vec[r] && !dec_vec[r]) begin
                if (cnt_q[r] == CNT_MAX) wb_err_d = 1'b1;
                else                     cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec_vec[r] && !inc_vec[r]) begin
                if (cnt_q[r] == '0) wb_err_d = 1'b1;
                else                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            wb_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            if (wr_en && !is_zero(wr_addr)) regs_q[wr_addr] <= wr_data;
            wb_err_q <= wb_err_d;
        end
    end

    always_comb begin
        rd_data_a = is_zero(rd_addr_a) ? '0 : regs_q[rd_addr_a];
        rd_data_b = is_zero(rd_addr_b) ? '0 : regs_q[rd_addr_b];
        hazard_a  = !is_zero(rd_addr_a) && (cnt_q[rd_addr_a] != '0);
        hazard_b  = !is_zero(rd_addr_b) && (cnt_q[rd_addr_b] != '0);
`ifdef RF_BYPASS_EN
        // A retiring writeback forwards its data and clears the hazard unless a new issue re-arms it.
        if (wr_en && (wr_addr == rd_addr_a) && !is_zero(rd_addr_a)) begin
            rd_data_a = wr_data;
            if ((cnt_q[rd_addr_a] == CNT_ONE) && !(iss_en && (iss_addr == rd_addr_a)))
                hazard_a = 1'b0;
        end
        if (wr_en && (wr_addr == rd_addr_b) && !is_zero(rd_addr_b)) begin
            rd_data_b = wr_data;
            if ((cnt_q[rd_addr_b] == CNT_ONE) && !(iss_en && (iss_addr == rd_addr_b)))
                hazard_b = 1'b0;
        end
`endif
        iss_full = !is_zero(iss_addr) && (cnt_q[iss_addr] == CNT_MAX);
        wb_err   = wb_err_q;
    end
endmodule

// File: tb/tb_mips_reg_file_sb.sv
// Randomized + directed bench for mips_reg_file_sb against an array-based reference model.
module tb_mips_reg_file_sb;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, iss_addr;
    logic [31:0] rd_data_a, rd_data_b, wr_data;
    logic        hazard_a, hazard_b, wr_en, iss_en, iss_full, wb_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [32];
    int          cnt_m [32];
    bit          err_m;

    always #5 clk = ~clk;

    mips_reg_file_sb dut (
        .clk(clk), .reset(reset),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .hazard_a(hazard_a), .hazard_b(hazard_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .iss_full(iss_full), .wb_err(wb_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            mem_m[r] = 32'h0;
            cnt_m[r] = 0;
        end
        err_m = 1'b0;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef RF_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
`endif
        return mem_m[a];
    endfunction

    function automatic logic exp_haz(input logic [4:0] a);
        if (a == 5'd0 || cnt_m[a] == 0) return 1'b0;
`ifdef RF_BYPASS_EN
        if (cnt_m[a] == 1 && wr_en && wr_addr == a && !(iss_en && iss_addr == a)) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // Apply inputs at negedge, then compare every output against the model's pre-edge view.
    task automatic drive(input logic ie, input logic [4:0] ia, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb);
        @(negedge clk);
        iss_en = ie; iss_addr = ia; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr_a = ra; rd_addr_b = rb;
        #1;
        check("rd_data_a", rd_data_a, exp_rd(ra));
        check("rd_data_b", rd_data_b, exp_rd(rb));
        check("hazard_a", {31'h0, hazard_a}, {31'h0, exp_haz(ra)});
        check("hazard_b", {31'h0, hazard_b}, {31'h0, exp_haz(rb)});
        check("iss_full", {31'h0, iss_full}, {31'h0, (ia != 5'd0 && cnt_m[ia] == 3)});
        check("wb_err", {31'h0, wb_err}, {31'h0, err_m});
    endtask

    task automatic tick();
        bit i, w;
        @(posedge clk);
        i = iss_en && iss_addr != 5'd0;
        w = wr_en && wr_addr != 5'd0;
        if (w) mem_m[wr_addr] = wr_data;
        if (!(i && w && iss_addr == wr_addr)) begin
            if (i) begin
                if (cnt_m[iss_addr] == 3) err_m = 1'b1;
                else cnt_m[iss_addr] = cnt_m[iss_addr] + 1;
            end
            if (w) begin
                if (cnt_m[wr_addr] == 0) err_m = 1'b1;
                else cnt_m[wr_addr] = cnt_m[wr_addr] - 1;
            end
        end
    endtask

    task automatic op(input logic ie, input logic [4:0] ia, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb);
        drive(ie, ia, we, wa, wd, ra, rb);
        tick();
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge, released at a negedge.
    task automatic pulse_reset(input logic [4:0] ra, input logic [4:0] rb);
        @(negedge clk);
        iss_en = 1'b0; wr_en = 1'b0; iss_addr = ra; rd_addr_a = ra; rd_addr_b = rb;
        #2 reset = 1'b0;
        #1;
        model_clear();
        check("rst_rd_a", rd_data_a, 32'h0);
        check("rst_rd_b", rd_data_b, 32'h0);
        check("rst_haz", {30'h0, hazard_a, hazard_b}, 32'h0);
        check("rst_full_err", {30'h0, iss_full, wb_err}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        iss_en = 1'b0; iss_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        op(0, 0, 0, 0, 0, 5, 31);

        // Zero register ignores writes without error.
        op(0, 0, 1, 0, 32'hDEADBEEF, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("r0_read", rd_data_a, 32'h0);
        check("r0_err", {31'h0, wb_err}, 32'h0);
        tick();

        // Basic write/read (these writes underflow, wb_err becomes sticky).
        op(0, 0, 1, 5, 32'h12345678, 0, 0);
        op(0, 0, 1, 31, 32'hFFFFFFFF, 0, 0);
        drive(0, 0, 0, 0, 0, 5, 31);
        check("rd_r5", rd_data_a, 32'h12345678);
        check("rd_r31", rd_data_b, 32'hFFFFFFFF);
        tick();

        // Scoreboard flow on r7.
        op(1, 7, 0, 0, 0, 7, 0);
        drive(0, 0, 0, 0, 0, 7, 0);
        check("haz_r7_1", {31'h0, hazard_a}, 32'h1);
        tick();
        op(1, 7, 0, 0, 0, 7, 7);
        drive(0, 0, 1, 7, 32'hA, 7, 0);
        check("haz_r7_wbA", {31'h0, hazard_a}, 32'h1);
        tick();
        op(0, 0, 1, 7, 32'hB, 7, 7);
        drive(0, 0, 0, 0, 0, 7, 7);
        check("haz_r7_done", {31'h0, hazard_a}, 32'h0);
        check("rd_r7_B", rd_data_b, 32'hB);
        tick();

        // Saturation on r3 after a clean reset.
        pulse_reset(3, 3);
        repeat (3) op(1, 3, 0, 0, 0, 3, 0);
        drive(0, 3, 0, 0, 0, 3, 0);
        check("sat_full", {31'h0, iss_full}, 32'h1);
        check("sat_noerr", {31'h0, wb_err}, 32'h0);
        tick();
        op(1, 3, 0, 0, 0, 3, 0);
        drive(0, 3, 0, 0, 0, 3, 0);
        check("sat_drop_err", {31'h0, wb_err}, 32'h1);
        tick();
        op(1, 3, 1, 3, 32'h77, 3, 3);
        drive(0, 3, 0, 0, 0, 3, 0);
        check("sat_same_full", {31'h0, iss_full}, 32'h1);
        check("sat_same_data", rd_data_a, 32'h77);
        tick();

        // Underflow on r9 after reset discards r3's pending entries.
        pulse_reset(3, 9);
        op(0, 3, 1, 9, 32'h55, 3, 9);
        drive(0, 0, 0, 0, 0, 9, 3);
        check("uf_data", rd_data_a, 32'h55);
        check("uf_haz", {30'h0, hazard_a, hazard_b}, 32'h0);
        check("uf_err", {31'h0, wb_err}, 32'h1);
        tick();
        op(0, 0, 0, 0, 0, 9, 9);
        check("uf_sticky", {31'h0, wb_err}, 32'h1);

        // Retiring writeback of the last pending entry on r4.
        op(0, 0, 1, 4, 32'h1111, 0, 4);
        op(1, 4, 0, 0, 0, 0, 4);
        drive(0, 0, 1, 4, 32'hCAFE, 0, 4);
`ifdef RF_BYPASS_EN
        check("byp_data", rd_data_b, 32'hCAFE);
        check("byp_haz", {31'h0, hazard_b}, 32'h0);
`else
        check("nobyp_data", rd_data_b, 32'h1111);
        check("nobyp_haz", {31'h0, hazard_b}, 32'h1);
`endif
        tick();

        // Random traffic over a small register window to provoke collisions.
        for (int n = 0; n < 600; n++) begin
            logic ie, we;
            logic [4:0] ia, wa, ra, rb;
            logic [31:0] wd;
            if (n == 300) pulse_reset(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            ie = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            ia = 5'($urandom_range(0, 7));
            wa = 5'($urandom_range(0, 7));
            wd = $urandom;
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 7));
            rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            op(ie, ia, we, wa, wd, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
